// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 op codes and default width.
package muldiv_pkg;
    localparam int MD_XLEN = 32;

    typedef logic [2:0] md_op_t;

    localparam md_op_t md_mul    = 3'd0;
    localparam md_op_t md_mulh   = 3'd1;
    localparam md_op_t md_mulhsu = 3'd2;
    localparam md_op_t md_mulhu  = 3'd3;
    localparam md_op_t md_div    = 3'd4;
    localparam md_op_t md_divu   = 3'd5;
    localparam md_op_t md_rem    = 3'd6;
    localparam md_op_t md_remu   = 3'd7;

    function automatic logic md_is_div(input md_op_t op);
        return op[2];
    endfunction
endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide, one bit per step,
// built around a single XLEN+1 adder/subtractor.
module muldiv_core import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            is_div,
    input  logic            step,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [XLEN-1:0] opnd;
    logic            div_mode;
    logic [XLEN:0]   add_a, add_b, sum;
    logic            sub;

    // hi:lo is the product register for mul, remainder:quotient for div.
    always_comb begin
        sub   = div_mode;
        add_b = {1'b0, opnd};
        if (div_mode) add_a = {hi, lo[XLEN-1]};
        else          add_a = {1'b0, hi};
        sum = sub ? (add_a + ~add_b + 1'b1) : (add_a + add_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            hi       <= '0;
            lo       <= opa;
            opnd     <= opb;
            div_mode <= is_div;
        end else if (step) begin
            if (div_mode) begin
                // negative trial difference means restore the shifted remainder
                hi <= sum[XLEN] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~sum[XLEN]};
            end else if (lo[0]) begin
                hi <= sum[XLEN:1];
                lo <= {sum[0], lo[XLEN-1:1]};
            end else begin
                hi <= {1'b0, hi[XLEN-1:1]};
                lo <= {hi[0], lo[XLEN-1:1]};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for EX: FSM, operand sign handling and special cases
// around the iterative muldiv_core; valid/ready on both request and result sides.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e          state;
    logic [CW-1:0]   counter;
    md_op_t          op_q;
    logic            neg_q;

    logic            accept;
    logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] fix_res;

    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        a_sgn  = (in_op == md_mulh) || (in_op == md_mulhsu) || (in_op == md_div) || (in_op == md_rem);
        b_sgn  = (in_op == md_mulh) || (in_op == md_div) || (in_op == md_rem);
        a_neg  = a_sgn && in_a[XLEN-1];
        b_neg  = b_sgn && in_b[XLEN-1];
        a_mag  = a_neg ? -in_a : in_a;
        b_mag  = b_neg ? -in_b : in_b;
        // remainder takes the dividend's sign; everything else the xor of both
        neg_in = (in_op == md_rem) ? a_neg : (a_neg ^ b_neg);

        div_zero = md_is_div(in_op) && (in_b == '0);
        div_ovf  = ((in_op == md_div) || (in_op == md_rem)) &&
                   (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = in_op[1] ? in_a : '1;
        else          special_res = in_op[1] ? '0   : in_a;
    end

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && !special),
        .is_div (md_is_div(in_op)),
        .step   (state == CALC),
        .opa    (a_mag),
        .opb    (b_mag),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    always_comb begin
        prod = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        case (op_q)
            md_mul:                      fix_res = prod[XLEN-1:0];
            md_mulh, md_mulhsu, md_mulhu: fix_res = prod[2*XLEN-1:XLEN];
            md_div, md_divu:             fix_res = neg_q ? -core_lo : core_lo;
            default:                     fix_res = neg_q ? -core_hi : core_hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            op_q       <= md_mul;
            neg_q      <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= in_op;
                    neg_q    <= neg_in;
                    in_ready <= 1'b0;
                    if (special) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= special_res;
                    end else begin
                        state   <= CALC;
                        counter <= CW'(XLEN-1);
                    end
                end
                CALC: begin
                    if (counter == '0) state <= FIX;
                    else               counter <= counter - 1'b1;
                end
                FIX: begin
                    out_result <= fix_res;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for the result, check latency/value, then consume it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output logic [31:0] res);
        int k;
        k = 0;
        while (!in_ready && k < 60) begin @(negedge clk); k++; end
        check({tag, " idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        k = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            k++;
            if (k == 1) check({tag, " busy"}, 32'(in_ready), 32'd0);
        end while (!out_valid && k < 40);
        check({tag, " latency"}, 32'(k), 32'(model_lat(op, a, b)));
        res = out_result;
        check({tag, " result"}, out_result, model(op, a, b));
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " drained"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic [31:0] r, held;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          k;
        logic        seen;

        #12;
        check("reset", {29'b0, in_ready, out_valid, |out_result}, 32'b100);
        @(negedge clk); rst = 1'b0;

        run_op(md_mul, 32'd7, -32'sd3, "mul 7*-3", r);        check("mul const", r, 32'hFFFFFFEB);
        run_op(md_mulh, 32'd7, -32'sd3, "mulh 7*-3", r);      check("mulh const", r, 32'hFFFFFFFF);
        run_op(md_mulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu max", r); check("mulhu const", r, 32'hFFFFFFFE);
        run_op(md_mulhsu, 32'hFFFFFFFF, 32'd2, "mulhsu -1*2", r); check("mulhsu const", r, 32'hFFFFFFFF);
        run_op(md_div, -32'sd7, 32'd2, "div -7/2", r);        check("div const", r, 32'hFFFFFFFD);
        run_op(md_rem, -32'sd7, 32'd2, "rem -7,2", r);        check("rem const", r, 32'hFFFFFFFF);
        run_op(md_divu, 32'd100, 32'd7, "divu 100/7", r);     check("divu const", r, 32'd14);
        run_op(md_remu, 32'd100, 32'd7, "remu 100/7", r);     check("remu const", r, 32'd2);
        run_op(md_div, 32'd1234, 32'd0, "div x/0", r);        check("div0 const", r, 32'hFFFFFFFF);
        run_op(md_remu, 32'd5, 32'd0, "remu 5/0", r);         check("remu0 const", r, 32'd5);
        run_op(md_div, 32'h80000000, 32'hFFFFFFFF, "div ovf", r); check("divovf const", r, 32'h80000000);
        run_op(md_rem, 32'h80000000, 32'hFFFFFFFF, "rem ovf", r); check("removf const", r, 32'd0);

        // result held while consumer stalls; a pending request must not be taken
        @(negedge clk); in_valid = 1'b1; in_op = md_mul; in_a = 32'd12345; in_b = 32'd678;
        @(posedge clk); #1; in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
        check("hold ready", 32'(out_valid), 32'd1);
        held = out_result;
        check("hold value", held, model(md_mul, 32'd12345, 32'd678));
        @(negedge clk); in_valid = 1'b1; in_op = md_divu; in_a = 32'd9; in_b = 32'd3;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_result !== held || in_ready) seen = 1'b1;
        end
        check("hold stable", 32'(seen), 32'd0);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("hold drain", {30'b0, out_valid, in_ready}, 32'b01);

        // flush in the middle of CALC
        @(negedge clk); in_valid = 1'b1; in_op = md_div; in_a = 32'd1000; in_b = 32'd3;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush idle", {30'b0, out_valid, in_ready}, 32'b01);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush no result", 32'(seen), 32'd0);
        run_op(md_rem, 32'd1000, 32'd7, "after flush", r);

        // flush wins over a simultaneous request
        @(negedge clk); in_valid = 1'b1; flush = 1'b1; in_op = md_mul; in_a = 32'd3; in_b = 32'd3;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        check("flush beats valid", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk); #1;
        check("flush beats valid ov", 32'(out_valid), 32'd0);

        // asynchronous reset mid-CALC
        @(negedge clk); in_valid = 1'b1; in_op = md_mulhu; in_a = 32'hDEADBEEF; in_b = 32'h12345678;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async rst", {29'b0, in_ready, out_valid, |out_result}, 32'b100);
        @(negedge clk); rst = 1'b0;

        // random ops against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
            run_op(rop, ra, rb, "random", r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
